// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the UART program loader.
// Latency: n/a (types only).
// Backpressure: n/a; the serial source cannot be stalled.
package uart_prog_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_CLEANUP
    } rx_state_t;

    localparam logic [31:0] END_WORD_DEF = 32'h0000_0FFF;
    localparam int          BYTE_CNT_W   = 2;

    // Drop byte b into lane idx of a little-endian 32-bit word.
    function automatic logic [31:0] put_byte(
        input logic [31:0]           w,
        input logic [BYTE_CNT_W-1:0] idx,
        input logic [7:0]            b
    );
        logic [31:0] r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, bit timer.
// Latency: byte_valid ~9.5 bit times + 3 clk after the start edge.
// Backpressure: none; byte_valid/frame_err are single-cycle pulses.
module uart_rx_8n1
    import uart_prog_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int             TMR_W     = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] LAST_BIT  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] LAST_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic [TMR_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic             half_done;
    logic             bit_done;

    logic             tmr_clr;
    logic             shift_en;
    logic             idx_clr;
    logic             valid_set;
    logic             ferr_set;

    // Line idles high, so the synchronizer resets to 1 to avoid a fake start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_serial};
        end
    end

    assign rx_s      = sync_q[1];
    assign half_done = (clk_cnt == LAST_HALF);
    assign bit_done  = (clk_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE: begin
                if (!rx_s) state_nxt = RX_START;
            end
            RX_START: begin
                if (half_done) state_nxt = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (bit_done && (bit_idx == 3'd7)) state_nxt = RX_STOP;
            end
            RX_STOP: begin
                if (bit_done) state_nxt = RX_CLEANUP;
            end
            RX_CLEANUP: begin
                state_nxt = RX_IDLE;
            end
            default: begin
                state_nxt = RX_IDLE;
            end
        endcase
    end

    always_comb begin
        tmr_clr   = 1'b1;
        shift_en  = 1'b0;
        idx_clr   = 1'b0;
        valid_set = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            RX_START: begin
                tmr_clr = half_done;
                idx_clr = 1'b1;
            end
            RX_DATA: begin
                tmr_clr  = bit_done;
                shift_en = bit_done;
            end
            RX_STOP: begin
                tmr_clr   = bit_done;
                valid_set = bit_done & rx_s;
                ferr_set  = bit_done & ~rx_s;
            end
            default: begin
                tmr_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt    <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_cnt    <= tmr_clr ? '0 : clk_cnt + 1'b1;
            byte_valid <= valid_set;
            frame_err  <= ferr_set;
            if (idx_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                rx_byte[bit_idx] <= rx_s;
            end
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: packs bytes LE into words, writes imem, releases core on END_WORD.
// Latency: mem_we one clk after the 4th byte's byte_valid.
// Backpressure: none; memory write is a fire-and-forget strobe, excess words flag overflow.
module uart_prog_loader
    import uart_prog_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 347,
    parameter int          ADDR_WIDTH   = 10,
    parameter logic [31:0] END_WORD     = END_WORD_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_serial,
    output logic                  ready_o,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  prog_done,
    output logic                  core_rst_n,
    output logic                  frame_err,
    output logic                  overflow
);

    logic [7:0]            rx_byte;
    logic                  byte_valid;
    logic                  rx_ferr;

    logic                  ready_q;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [31:0]           word_buf;
    logic [31:0]           full_word;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  mem_full;
    logic                  accept;
    logic                  word_done;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_serial (rx_serial),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (rx_ferr)
    );

    // Once loaded, the receiver keeps running but its bytes are ignored.
    assign accept    = byte_valid & ~prog_done;
    assign word_done = accept & (byte_cnt == {BYTE_CNT_W{1'b1}});
    assign full_word = put_byte(word_buf, byte_cnt, rx_byte);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b0;
            byte_cnt  <= '0;
            word_buf  <= '0;
            wr_ptr    <= '0;
            mem_full  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            prog_done <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            mem_we  <= 1'b0;
            if (accept) begin
                word_buf <= full_word;
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (word_done) begin
                if (full_word == END_WORD) begin
                    prog_done <= 1'b1;
                end else if (!mem_full) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= wr_ptr;
                    mem_wdata <= full_word;
                    // Saturate at the top address instead of wrapping over code.
                    if (wr_ptr == {ADDR_WIDTH{1'b1}}) begin
                        mem_full <= 1'b1;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign ready_o    = ready_q & ~prog_done;
    assign core_rst_n = prog_done;
    assign frame_err  = rx_ferr;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: single word, terminator, glitch, framing, overflow, reset.
module tb_uart_prog_loader;
    import uart_prog_pkg::*;

    localparam int CPB = 4;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_serial = 1'b1;
    logic          ready_o;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          prog_done;
    logic          core_rst_n;
    logic          frame_err;
    logic          overflow;

    int compared   = 0;
    int mismatched = 0;

    int            we_cnt = 0;
    int            bv_cnt = 0;
    int            fe_cnt = 0;
    int            cyc = 0;
    int            last_bv_cyc = 0;
    int            done_cyc = 0;
    logic          done_q = 1'b0;
    logic [AW-1:0] log_addr [0:63];
    logic [31:0]   log_data [0:63];

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW),
        .END_WORD    (32'h0000_0FFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_serial (rx_serial),
        .ready_o   (ready_o),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .prog_done (prog_done),
        .core_rst_n(core_rst_n),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        done_q <= prog_done;
        if (rst_n) begin
            if (mem_we) begin
                if (we_cnt < 64) begin
                    log_addr[we_cnt] <= mem_addr;
                    log_data[we_cnt] <= mem_wdata;
                end
                we_cnt <= we_cnt + 1;
            end
            if (dut.u_rx.byte_valid) begin
                bv_cnt      <= bv_cnt + 1;
                last_bv_cyc <= cyc;
            end
            if (frame_err) fe_cnt <= fe_cnt + 1;
            if (prog_done && !done_q) done_cyc <= cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], 1'b1);
        end
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({ready_o, mem_we, mem_addr, mem_wdata, prog_done, core_rst_n, frame_err, overflow} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got ready=%b we=%b addr=%h wdata=%h done=%b crst=%b ferr=%b ovf=%b, expected all 0",
                     ready_o, mem_we, mem_addr, mem_wdata, prog_done, core_rst_n, frame_err, overflow);
        end
        compared++;
        if (dut.u_rx.state !== RX_IDLE) begin
            mismatched++;
            $display("FAIL reset_rx_state: got %0d expected %0d", dut.u_rx.state, RX_IDLE);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (ready_o !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_after_reset: got %b expected 1", ready_o);
        end
    endtask

    task automatic test_single_word();
        int b;
        do_reset();
        b = we_cnt;
        send_word(32'h1234_5678);
        settle();
        compared++;
        if (we_cnt - b != 1) begin
            mismatched++;
            $display("FAIL single_write_count: got %0d expected 1", we_cnt - b);
        end
        compared++;
        if (log_addr[b] !== 2'd0 || log_data[b] !== 32'h1234_5678) begin
            mismatched++;
            $display("FAIL single_write: got addr=%h data=%h expected addr=0 data=12345678", log_addr[b], log_data[b]);
        end
        compared++;
        if (prog_done !== 1'b0 || mem_wdata !== 32'h1234_5678 || mem_we !== 1'b0) begin
            mismatched++;
            $display("FAIL single_hold: got done=%b wdata=%h we=%b expected done=0 wdata=12345678 we=0", prog_done, mem_wdata, mem_we);
        end
    endtask

    task automatic test_terminator();
        int b;
        int b2;
        do_reset();
        b = we_cnt;
        send_word(32'hDEAD_BEEF);
        send_word(32'h0000_0013);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h0F, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        settle();
        compared++;
        if (we_cnt - b != 2) begin
            mismatched++;
            $display("FAIL term_write_count: got %0d expected 2", we_cnt - b);
        end
        compared++;
        if (log_addr[b] !== 2'd0 || log_data[b] !== 32'hDEAD_BEEF ||
            log_addr[b+1] !== 2'd1 || log_data[b+1] !== 32'h0000_0013) begin
            mismatched++;
            $display("FAIL term_writes: got %h@%h %h@%h expected deadbeef@0 00000013@1",
                     log_data[b], log_addr[b], log_data[b+1], log_addr[b+1]);
        end
        compared++;
        if (prog_done !== 1'b1 || core_rst_n !== 1'b1 || ready_o !== 1'b0) begin
            mismatched++;
            $display("FAIL term_done: got done=%b crst=%b ready=%b expected 1 1 0", prog_done, core_rst_n, ready_o);
        end
        compared++;
        if (done_cyc - last_bv_cyc != 1) begin
            mismatched++;
            $display("FAIL term_latency: got %0d cycles expected 1", done_cyc - last_bv_cyc);
        end
        b2 = we_cnt;
        send_word(32'h0000_0055);
        settle();
        compared++;
        if (we_cnt != b2 || prog_done !== 1'b1 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL post_done_suppress: got writes=%0d done=%b ovf=%b expected 0 1 0", we_cnt - b2, prog_done, overflow);
        end
    endtask

    task automatic test_glitch();
        int bb;
        int fb;
        int b;
        do_reset();
        bb = bv_cnt;
        fb = fe_cnt;
        b  = we_cnt;
        @(negedge clk);
        rx_serial = 1'b0;
        @(negedge clk);
        rx_serial = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        compared++;
        if (bv_cnt != bb || fe_cnt != fb) begin
            mismatched++;
            $display("FAIL glitch_spurious: got bytes=%0d ferr=%0d expected 0 0", bv_cnt - bb, fe_cnt - fb);
        end
        send_byte(8'hA5, 1'b1);
        settle();
        compared++;
        if (bv_cnt - bb != 1 || dut.u_rx.rx_byte !== 8'hA5) begin
            mismatched++;
            $display("FAIL glitch_byte: got count=%0d byte=%h expected 1 a5", bv_cnt - bb, dut.u_rx.rx_byte);
        end
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        settle();
        compared++;
        if (we_cnt - b != 1 || log_data[b] !== 32'h0000_00A5 || log_addr[b] !== 2'd0) begin
            mismatched++;
            $display("FAIL glitch_word: got n=%0d %h@%h expected 1 000000a5@0", we_cnt - b, log_data[b], log_addr[b]);
        end
    endtask

    task automatic test_frame_err();
        int fb;
        int bb;
        int b;
        do_reset();
        fb = fe_cnt;
        bb = bv_cnt;
        b  = we_cnt;
        send_byte(8'h11, 1'b0);
        settle();
        compared++;
        if (fe_cnt - fb != 1 || bv_cnt != bb) begin
            mismatched++;
            $display("FAIL ferr_pulse: got ferr=%0d bytes=%0d expected 1 0", fe_cnt - fb, bv_cnt - bb);
        end
        send_word(32'h4433_2211);
        settle();
        compared++;
        if (fe_cnt - fb != 1 || we_cnt - b != 1 || log_data[b] !== 32'h4433_2211 || log_addr[b] !== 2'd0) begin
            mismatched++;
            $display("FAIL ferr_word: got ferr=%0d n=%0d %h@%h expected 1 1 44332211@0",
                     fe_cnt - fb, we_cnt - b, log_data[b], log_addr[b]);
        end
    endtask

    task automatic test_overflow();
        int b;
        logic [31:0] w;
        do_reset();
        b = we_cnt;
        for (int i = 0; i < 4; i++) begin
            w = 32'hA000_0000 + 32'(i) * 32'h0000_0101;
            send_word(w);
        end
        settle();
        compared++;
        if (we_cnt - b != 4 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_fill: got n=%0d ovf=%b expected 4 0", we_cnt - b, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            w = 32'hA000_0000 + 32'(i) * 32'h0000_0101;
            compared++;
            if (log_addr[b+i] !== AW'(i) || log_data[b+i] !== w) begin
                mismatched++;
                $display("FAIL ovf_write%0d: got %h@%h expected %h@%h", i, log_data[b+i], log_addr[b+i], w, i);
            end
        end
        send_word(32'hB000_0005);
        settle();
        compared++;
        if (we_cnt - b != 4 || overflow !== 1'b1 || mem_addr !== 2'd3) begin
            mismatched++;
            $display("FAIL ovf_5th: got n=%0d ovf=%b addr=%h expected 4 1 3", we_cnt - b, overflow, mem_addr);
        end
        send_word(32'h0000_0FFF);
        settle();
        compared++;
        if (prog_done !== 1'b1 || overflow !== 1'b1 || we_cnt - b != 4) begin
            mismatched++;
            $display("FAIL ovf_term: got done=%b ovf=%b n=%0d expected 1 1 4", prog_done, overflow, we_cnt - b);
        end
    endtask

    task automatic test_reset_mid_word();
        int b;
        do_reset();
        b = we_cnt;
        send_byte(8'hC3, 1'b1);
        send_byte(8'h3C, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (mem_addr !== 2'd0 || prog_done !== 1'b0 || ready_o !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_state: got addr=%h done=%b ready=%b expected 0 0 0", mem_addr, prog_done, ready_o);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_word(32'h0000_00AA);
        settle();
        compared++;
        if (we_cnt - b != 1 || log_data[b] !== 32'h0000_00AA || log_addr[b] !== 2'd0) begin
            mismatched++;
            $display("FAIL midreset_word: got n=%0d %h@%h expected 1 000000aa@0", we_cnt - b, log_data[b], log_addr[b]);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_terminator();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
